// File: rtl/matrix_mult_nxn_pipe.sv
// Unsigned NxN matrix multiplier C = A x B: one element per cycle through N parallel
// multipliers, a registered product stage and a registered sum/clamp stage.
module matrix_mult_nxn_pipe #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sat_en,
  input  logic [N*N*DW-1:0]   matrix_a,
  input  logic [N*N*DW-1:0]   matrix_b,
  output logic                busy,
  output logic [N*N*OW-1:0]   result,
  output logic                valid_out,
  output logic                overflow
);

  localparam int unsigned NN    = N * N;
  localparam int unsigned IW    = $clog2(NN);
  localparam int unsigned RW    = $clog2(N);
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned ACC_W = 2 * DW + $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [RW-1:0]     row;
  logic [RW-1:0]     col;
  logic              sat_q;
  logic              ovf_acc;
  logic              drain_cnt;
  logic              s1_valid;
  logic [IW-1:0]     s1_idx;
  logic [DW-1:0]     a_q   [N][N];
  logic [DW-1:0]     b_q   [N][N];
  logic [PW-1:0]     p_q   [N];
  logic [OW-1:0]     buf_q [NN];

  logic [PW-1:0]     prod_c [N];
  logic [ACC_W-1:0]  sum_c;
  logic              ovf_c;
  logic [OW-1:0]     elem_c;

  // Row r of A against column c of B for the element being issued
  always_comb begin
    for (int k = 0; k < N; k++) begin
      prod_c[k] = PW'(a_q[row][k]) * PW'(b_q[k][col]);
    end
  end

  // Full-precision sum of the registered products, then saturate or truncate
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N; k++) begin
      sum_c = sum_c + ACC_W'(p_q[k]);
    end
    ovf_c  = (sum_c > ACC_W'({OW{1'b1}}));
    elem_c = (sat_q && ovf_c) ? {OW{1'b1}} : sum_c[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      sat_q     <= 1'b0;
      ovf_acc   <= 1'b0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
      for (int r = 0; r < N; r++) begin
        p_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
      for (int i = 0; i < NN; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      s1_valid  <= 1'b0;

      // Stage 2 retires whatever stage 1 registered on the previous edge
      if (s1_valid) begin
        buf_q[s1_idx] <= elem_c;
        if (ovf_c) begin
          ovf_acc <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                a_q[r][c] <= matrix_a[(r*N+c)*DW +: DW];
                b_q[r][c] <= matrix_b[(r*N+c)*DW +: DW];
              end
            end
            sat_q   <= sat_en;
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            p_q[k] <= prod_c[k];
          end
          s1_idx   <= idx;
          s1_valid <= 1'b1;
          idx      <= idx + IW'(1);
          if (col == RW'(N - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + RW'(1);
          end
          if (idx == IW'(NN - 1)) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            for (int i = 0; i < NN; i++) begin
              result[i*OW +: OW] <= buf_q[i];
            end
            overflow  <= ovf_acc;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_nxn_pipe.sv
// Directed self-checking bench for matrix_mult_nxn_pipe at N=3, DW=8, OW=8.
module tb_matrix_mult_nxn_pipe;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sat_en;
  logic [71:0] matrix_a;
  logic [71:0] matrix_b;
  logic        busy;
  logic [71:0] result;
  logic        valid_out;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [71:0] m_id, m_seq, m_a19, m_b91, m_c, m_ff, m_03;

  matrix_mult_nxn_pipe #(.N(3), .DW(8), .OW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sat_en    (sat_en),
    .matrix_a  (matrix_a),
    .matrix_b  (matrix_b),
    .busy      (busy),
    .result    (result),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [71:0] pk(input int unsigned e [9]);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(e[i]);
    return v;
  endfunction

  // Caller is positioned 1 time unit after a rising edge with the DUT idle.
  task automatic run_job(input logic [71:0] a, input logic [71:0] b, input logic s,
                         output int lat);
    matrix_a = a;
    matrix_b = b;
    sat_en   = s;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("job_completed", valid_out, 1'b1);
    check("busy_at_valid", busy, 1'b0);
  endtask

  initial begin
    int unsigned tmp [9];
    int lat, pulses, first, k, last_t;
    logic prev_v;
    logic [71:0] exp_q [3];

    tmp = '{1, 0, 0, 0, 1, 0, 0, 0, 1};           m_id  = pk(tmp);
    tmp = '{1, 2, 3, 4, 5, 6, 7, 8, 9};           m_seq = pk(tmp);
    m_a19 = m_seq;
    tmp = '{9, 8, 7, 6, 5, 4, 3, 2, 1};           m_b91 = pk(tmp);
    tmp = '{30, 24, 18, 84, 69, 54, 138, 114, 90}; m_c   = pk(tmp);
    m_ff = {9{8'hFF}};
    m_03 = {9{8'h03}};

    rst_n = 1'b0; start = 1'b0; sat_en = 1'b0; matrix_a = '0; matrix_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_result", result, 72'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity times sequence, including latency
    run_job(m_id, m_seq, 1'b0, lat);
    check("id_latency", 32'(lat), 32'd11);
    check("id_result", result, m_seq);
    check("id_overflow", overflow, 1'b0);
    @(posedge clk); #1;
    check("valid_one_cycle", valid_out, 1'b0);

    run_job(m_a19, m_b91, 1'b0, lat);
    check("seq_result", result, m_c);
    check("seq_overflow", overflow, 1'b0);

    // Start re-pulsed while busy, matrix_a corrupted mid-job
    matrix_a = m_a19; matrix_b = m_b91; sat_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pulses = 0; first = 0;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i == 2) matrix_a = m_ff;
      start = (i == 3 || i == 9);
    end
    start = 1'b0;
    check("midjob_pulses", 32'(pulses), 32'd1);
    check("midjob_latency", 32'(first), 32'd11);
    check("midjob_result", result, m_c);

    run_job(m_ff, m_ff, 1'b1, lat);
    check("sat_result", result, m_ff);
    check("sat_overflow", overflow, 1'b1);
    run_job(m_ff, m_ff, 1'b0, lat);
    check("trunc_result", result, m_03);
    check("trunc_overflow", overflow, 1'b1);

    // Reset mid-run aborts the job
    matrix_a = m_a19; matrix_b = m_b91; sat_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", valid_out, 1'b0);
    check("abort_overflow", overflow, 1'b0);
    check("abort_result", result, 72'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_out) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    run_job(m_id, m_seq, 1'b0, lat);
    check("post_reset_result", result, m_seq);
    check("post_reset_latency", 32'(lat), 32'd11);

    // Held start: back-to-back jobs
    exp_q[0] = m_seq; exp_q[1] = m_c; exp_q[2] = m_ff;
    matrix_a = m_id; matrix_b = m_seq; sat_en = 1'b0; start = 1'b1;
    k = 0; last_t = 0; prev_v = 1'b0;
    for (int i = 1; i <= 60 && k < 3; i++) begin
      @(posedge clk); #1;
      if (prev_v) check("held_valid_single", valid_out, 1'b0);
      prev_v = valid_out;
      if (valid_out) begin
        check($sformatf("held_result_%0d", k), result, exp_q[k]);
        if (k > 0) check($sformatf("held_gap_%0d", k), 32'(i - last_t), 32'd12);
        last_t = i;
        k++;
        if (k == 1) begin matrix_a = m_a19; matrix_b = m_b91; end
        if (k == 2) begin matrix_a = m_ff;  matrix_b = m_ff; sat_en = 1'b1; end
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_job_count", 32'(k), 32'd3);
    @(posedge clk); #1;
    check("held_last_single", valid_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
